event_dispatcher: RTL and testbench
===================================

// Module: event_dispatcher
// PURPOSE
//  Sits between the event queue and the cores, upstream of the core monitor. Pops events from the
//  queue and dispatches them to idle cores. Arbitrates round-robin among cores returning newly
//  generated events and pushes those events back into the queue. Serialises both flows onto the
//  single monitor bus (msg/sent_msg_vld/rcv_msg_vld/core_id) and owns the core_active vector.
// PARAMETERS
//  NUM_CORE       4                  number of cores
//  NB_COREID      $clog2(NUM_CORE)   core index width
//  MSG_WID        32                 event message width; time in [TIME_WID-1:0]
//  TIME_WID       16                 timestamp width
//  MAX_RET_BURST  4                  consecutive return grants before one dispatch is forced
//  WINDOW         256                dispatch window width, used only with DISPATCH_WINDOW_EN
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  asynchronous, active-high
//  q_data         in   MSG_WID            queue head (first-word-fall-through)
//  q_empty        in   1                  queue has no event
//  q_full         in   1                  queue cannot accept an enqueue
//  q_deq          out  1                  pop head this cycle (combinational)
//  q_enq          out  1                  push q_enq_data (registered)
//  q_enq_data     out  MSG_WID            returned event to enqueue
//  core_req       in   NUM_CORE           core i holds a generated event on core_msg[i]
//  core_msg       in   NUM_CORE*MSG_WID   per-core return message, slice i = [i*MSG_WID +: MSG_WID]
//  core_done      in   NUM_CORE           1-cycle pulse: core i finished its event
//  core_ack       out  NUM_CORE           1-cycle one-hot grant of core_req (registered)
//  core_evt_vld   out  NUM_CORE           1-cycle one-hot: event on core_evt_data is for core i
//  core_evt_data  out  MSG_WID            dispatched event
//  mon_msg        out  MSG_WID            monitor bus message
//  sent_msg_vld   out  1                  mon_msg is a dispatch to core mon_core_id
//  rcv_msg_vld    out  1                  mon_msg is a return from core mon_core_id
//  mon_core_id    out  NB_COREID          core on the monitor bus
//  core_active    out  NUM_CORE           core holds an event
//  min_time       in   TIME_WID           from the core monitor (window check only)
//  min_time_vld   in   1                  min_time is valid
// BEHAVIOUR
//  - Reset: all outputs 0; core_active=0; RR pointer=0; burst counter=0. A reset mid-op drops
//    in-flight grants. Cores are reset together with this block.
//  - Decision cycle N, at most one op: RET (return), DSP (dispatch) or NONE. Registered outputs
//    take effect at N+1. q_deq is asserted combinationally in cycle N for DSP only.
//  - RET eligible: |core_req && !q_full. The winner is the first requesting core at or after
//    rr_ptr, wrapping mod NUM_CORE. After the grant, rr_ptr = winner+1 (wraps at NUM_CORE-1).
//  - DSP eligible: !q_empty && some core has core_active=0. Target: lowest-index idle core.
//  - Priority: RET over DSP. Exception: when burst_cnt == MAX_RET_BURST and DSP is eligible,
//    DSP wins and burst_cnt clears. burst_cnt increments on RET and clears on DSP or NONE.
//    It saturates at MAX_RET_BURST.
//  - On RET at N+1: core_ack[w]=1, q_enq=1, q_enq_data=mon_msg=core_msg[w], rcv_msg_vld=1,
//    mon_core_id=w. The core drops core_req the cycle after core_ack.
//  - On DSP at N+1: core_evt_vld[t]=1, core_evt_data=mon_msg=q_data(N), sent_msg_vld=1,
//    mon_core_id=t, and core_active[t] is set in the same cycle.
//  - sent_msg_vld and rcv_msg_vld are never both 1. The bus holds its last value when idle.
//  - core_done[i] clears core_active[i] at the next edge. A core freed at N is eligible at N+1.
//    If core_done[i] arrives during the DSP decision that targets core i, set wins.
//  - Target selection uses the registered core_active. A core is never dispatched twice
//    without an intervening core_done.
//  - q_full only blocks RET. q_empty only blocks DSP. With both blocked the op is NONE.
// CONFIGURATION
//  DISPATCH_WINDOW_EN defined: DSP additionally requires
//    !min_time_vld || (q_data[TIME_WID-1:0] - min_time) < WINDOW. The subtraction is unsigned,
//    TIME_WID bits, with wrap-around. A blocked head stalls dispatch; it does not block RET.
//  DISPATCH_WINDOW_EN undefined: no window check; min_time and min_time_vld are ignored.
// TESTING
//  1. Reset, then queue holds 3 events at t=5,7,9 and all cores are idle -> dispatched to
//     cores 0,1,2 on consecutive cycles; core_active=4'b0111; three sent_msg_vld pulses.
//  2. core_req=4'b1111 and q_empty -> acks go to cores 0,1,2,3,0 in order; q_enq every cycle;
//     rcv_msg_vld with mon_core_id matching each ack.
//  3. core_req held at 4'b0010 and queue non-empty, MAX_RET_BURST=4 -> 4 RET ops, then 1 DSP,
//     then RET resumes.
//  4. All cores active and core_done[2] pulses at cycle N -> core 2 receives the head event
//     at N+2, with core_evt_vld=4'b0100.
//  5. q_full=1 and core_req=4'b0001 -> no core_ack and no q_enq; DSP still proceeds.
//     Then drop q_full -> ack in the next decision cycle.
//  6. With DISPATCH_WINDOW_EN, min_time=100 and head t=400 -> no q_deq. Raise min_time to 200
//     -> dispatch occurs. Also: reset asserted mid-RET -> every output is 0 immediately.

Source files
------------

// File: rtl/event_dispatcher.sv
// -----------------------------------------------------------------------------
// event_dispatcher
//
// Purpose:
//   Sits between the event queue and the cores, upstream of the core monitor.
//   Each cycle it makes at most one decision:
//     RET  - grant one core (round-robin) that is returning a generated event,
//            and push that event back into the queue.
//     DSP  - pop the queue head and hand it to the lowest-index idle core.
//     NONE - nothing to do.
//   Both flows are serialised onto the single monitor bus. The block owns the
//   core_active vector, which tracks which cores currently hold an event.
//
// Optional feature:
//   `define DISPATCH_WINDOW_EN to hold dispatch back while the head timestamp
//   is WINDOW or more ticks ahead of the monitor's min_time. Without the macro
//   min_time and min_time_vld are ignored.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   q_data, q_empty   queue head (first-word-fall-through) and empty flag
//   q_full            queue cannot accept an enqueue
//   q_deq             pop head this cycle (combinational)
//   q_enq, q_enq_data push a returned event (registered)
//   core_req/msg      per-core return request and message
//   core_done         per-core completion pulse
//   core_ack          one-hot return grant (registered)
//   core_evt_vld/data one-hot dispatch strobe and dispatched event
//   mon_msg, sent_msg_vld, rcv_msg_vld, mon_core_id   monitor bus
//   core_active       cores currently holding an event
//   min_time(_vld)    earliest outstanding time from the core monitor
// -----------------------------------------------------------------------------
module event_dispatcher #(
  parameter int NUM_CORE      = 4,
  parameter int NB_COREID     = $clog2(NUM_CORE),
  parameter int MSG_WID       = 32,
  parameter int TIME_WID      = 16,
  parameter int MAX_RET_BURST = 4,
  parameter int WINDOW        = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MSG_WID-1:0]          q_data,
  input  logic                        q_empty,
  input  logic                        q_full,
  output logic                        q_deq,
  output logic                        q_enq,
  output logic [MSG_WID-1:0]          q_enq_data,
  input  logic [NUM_CORE-1:0]         core_req,
  input  logic [NUM_CORE*MSG_WID-1:0] core_msg,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic [NUM_CORE-1:0]         core_ack,
  output logic [NUM_CORE-1:0]         core_evt_vld,
  output logic [MSG_WID-1:0]          core_evt_data,
  output logic [MSG_WID-1:0]          mon_msg,
  output logic                        sent_msg_vld,
  output logic                        rcv_msg_vld,
  output logic [NB_COREID-1:0]        mon_core_id,
  output logic [NUM_CORE-1:0]         core_active,
  input  logic [TIME_WID-1:0]         min_time,
  input  logic                        min_time_vld
);

  localparam int BURST_WID = $clog2(MAX_RET_BURST + 1);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RET  = 2'd1,
    OP_DSP  = 2'd2
  } op_t;

  op_t                  op;
  logic [NB_COREID-1:0] rr_ptr;
  logic [BURST_WID-1:0] burst_cnt;
  logic                 burst_at_max;

  logic [NB_COREID-1:0] ret_win;
  logic [NB_COREID-1:0] ret_idx;
  logic                 ret_found;
  logic [MSG_WID-1:0]   ret_msg;
  logic [NB_COREID-1:0] dsp_tgt;
  logic                 dsp_found;
  logic                 window_ok;
  logic                 ret_ok;
  logic                 dsp_ok;

`ifdef DISPATCH_WINDOW_EN
  // Unsigned TIME_WID-bit difference so that timestamp wrap-around is handled.
  logic [TIME_WID-1:0] time_diff;
  assign time_diff = q_data[TIME_WID-1:0] - min_time;
  assign window_ok = !min_time_vld || (32'(time_diff) < 32'(WINDOW));
`else
  logic unused_window;
  assign unused_window = ^{min_time, min_time_vld};
  assign window_ok     = 1'b1;
`endif

  // Round-robin search: first requesting core at or after rr_ptr, wrapping.
  always_comb begin
    ret_win   = '0;
    ret_idx   = '0;
    ret_found = 1'b0;
    for (int k = 0; k < NUM_CORE; k++) begin
      ret_idx = NB_COREID'((int'(rr_ptr) + k) % NUM_CORE);
      if (!ret_found && core_req[ret_idx]) begin
        ret_found = 1'b1;
        ret_win   = ret_idx;
      end
    end
  end

  assign ret_msg = core_msg[int'(ret_win)*MSG_WID +: MSG_WID];

  // Lowest-index idle core, taken from the registered core_active so a core
  // just dispatched this cycle can never be picked again before core_done.
  always_comb begin
    dsp_tgt   = '0;
    dsp_found = 1'b0;
    for (int k = NUM_CORE - 1; k >= 0; k--) begin
      if (!core_active[k]) begin
        dsp_found = 1'b1;
        dsp_tgt   = NB_COREID'(k);
      end
    end
  end

  assign burst_at_max = (burst_cnt == BURST_WID'(MAX_RET_BURST));
  assign ret_ok       = ret_found && !q_full;
  assign dsp_ok       = !q_empty && dsp_found && window_ok;

  // Returns normally win; a saturated return burst yields one slot to dispatch
  // so the queue cannot be starved by chatty cores.
  always_comb begin
    op = OP_NONE;
    if (ret_ok && !(burst_at_max && dsp_ok)) begin
      op = OP_RET;
    end else if (dsp_ok) begin
      op = OP_DSP;
    end
  end

  // Gated with reset so every output reads 0 while reset is held.
  assign q_deq = (op == OP_DSP) && !reset;

  // Decision register: strobes are single-cycle, bus data holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      q_enq         <= 1'b0;
      q_enq_data    <= '0;
      core_ack      <= '0;
      core_evt_vld  <= '0;
      core_evt_data <= '0;
      mon_msg       <= '0;
      sent_msg_vld  <= 1'b0;
      rcv_msg_vld   <= 1'b0;
      mon_core_id   <= '0;
      core_active   <= '0;
    end else begin
      q_enq        <= 1'b0;
      core_ack     <= '0;
      core_evt_vld <= '0;
      sent_msg_vld <= 1'b0;
      rcv_msg_vld  <= 1'b0;
      core_active  <= core_active & ~core_done;
      case (op)
        OP_RET: begin
          core_ack[ret_win] <= 1'b1;
          q_enq             <= 1'b1;
          q_enq_data        <= ret_msg;
          mon_msg           <= ret_msg;
          rcv_msg_vld       <= 1'b1;
          mon_core_id       <= ret_win;
          rr_ptr            <= (ret_win == NB_COREID'(NUM_CORE - 1)) ?
                               '0 : ret_win + NB_COREID'(1);
          if (!burst_at_max) begin
            burst_cnt <= burst_cnt + BURST_WID'(1);
          end
        end
        OP_DSP: begin
          // Set after the core_done clear above, so set wins on a collision.
          core_evt_vld[dsp_tgt] <= 1'b1;
          core_evt_data         <= q_data;
          mon_msg               <= q_data;
          sent_msg_vld          <= 1'b1;
          mon_core_id           <= dsp_tgt;
          core_active[dsp_tgt]  <= 1'b1;
          burst_cnt             <= '0;
        end
        default: begin
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_event_dispatcher
//
// Self-checking bench for event_dispatcher. The bench owns the event queue
// (an SV queue) and a cycle-level reference model of the dispatcher built from
// the behavioural rules: which op happens, which core wins, what the monitor
// bus shows. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_event_dispatcher;

  localparam int NUM_CORE      = 4;
  localparam int NB_COREID     = 2;
  localparam int MSG_WID       = 32;
  localparam int TIME_WID      = 16;
  localparam int MAX_RET_BURST = 4;
  localparam int WINDOW        = 256;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [MSG_WID-1:0]          q_data;
  logic                        q_empty;
  logic                        q_full;
  logic                        q_deq;
  logic                        q_enq;
  logic [MSG_WID-1:0]          q_enq_data;
  logic [NUM_CORE-1:0]         core_req;
  logic [NUM_CORE*MSG_WID-1:0] core_msg;
  logic [NUM_CORE-1:0]         core_done;
  logic [NUM_CORE-1:0]         core_ack;
  logic [NUM_CORE-1:0]         core_evt_vld;
  logic [MSG_WID-1:0]          core_evt_data;
  logic [MSG_WID-1:0]          mon_msg;
  logic                        sent_msg_vld;
  logic                        rcv_msg_vld;
  logic [NB_COREID-1:0]        mon_core_id;
  logic [NUM_CORE-1:0]         core_active;
  logic [TIME_WID-1:0]         min_time;
  logic                        min_time_vld;

  always #5 clk = ~clk;

  event_dispatcher #(
    .NUM_CORE(NUM_CORE), .NB_COREID(NB_COREID), .MSG_WID(MSG_WID),
    .TIME_WID(TIME_WID), .MAX_RET_BURST(MAX_RET_BURST), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset(reset),
    .q_data(q_data), .q_empty(q_empty), .q_full(q_full), .q_deq(q_deq),
    .q_enq(q_enq), .q_enq_data(q_enq_data),
    .core_req(core_req), .core_msg(core_msg), .core_done(core_done),
    .core_ack(core_ack), .core_evt_vld(core_evt_vld), .core_evt_data(core_evt_data),
    .mon_msg(mon_msg), .sent_msg_vld(sent_msg_vld), .rcv_msg_vld(rcv_msg_vld),
    .mon_core_id(mon_core_id), .core_active(core_active),
    .min_time(min_time), .min_time_vld(min_time_vld)
  );

  int errCount   = 0;
  int checkCount = 0;

  logic [MSG_WID-1:0] fifo[$];

  // Reference model state and expected registered outputs.
  logic [NUM_CORE-1:0]  mActive;
  int                   mRr;
  int                   mBurst;
  logic [NUM_CORE-1:0]  eAck, eEvt;
  logic                 eEnq, eSent, eRcv, eQDeq;
  logic [MSG_WID-1:0]   eEnqData, eEvtData, eMon;
  logic [NB_COREID-1:0] eId;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mActive = '0; mRr = 0; mBurst = 0;
    eAck = '0; eEvt = '0; eEnq = 1'b0; eSent = 1'b0; eRcv = 1'b0; eQDeq = 1'b0;
    eEnqData = '0; eEvtData = '0; eMon = '0; eId = '0;
  endtask

  // One decision: who may go, who wins, and what shows up one cycle later.
  task automatic modelDecide();
    bit retOk, dspOk, winOk;
    int w, t, c;
    logic [NUM_CORE-1:0] nextActive;
    retOk = (core_req != '0) && !q_full;
    winOk = 1'b1;
`ifdef DISPATCH_WINDOW_EN
    if (min_time_vld)
      winOk = (((int'(q_data[TIME_WID-1:0]) - int'(min_time)) + 65536) % 65536) < WINDOW;
`endif
    dspOk = (fifo.size() > 0) && (mActive != '1) && winOk;
    nextActive = mActive & ~core_done;
    eAck = '0; eEvt = '0; eEnq = 1'b0; eSent = 1'b0; eRcv = 1'b0; eQDeq = 1'b0;
    if (retOk && !(mBurst == MAX_RET_BURST && dspOk)) begin
      w = -1;
      for (int k = 0; k < NUM_CORE; k++) begin
        c = (mRr + k) % NUM_CORE;
        if (w < 0 && core_req[c]) w = c;
      end
      eAck[w]  = 1'b1;
      eEnq     = 1'b1;
      eEnqData = core_msg[w*MSG_WID +: MSG_WID];
      eMon     = eEnqData;
      eRcv     = 1'b1;
      eId      = NB_COREID'(w);
      mRr      = (w + 1) % NUM_CORE;
      mBurst   = (mBurst < MAX_RET_BURST) ? mBurst + 1 : MAX_RET_BURST;
    end else if (dspOk) begin
      t = 0;
      while (mActive[t]) t++;
      eQDeq         = 1'b1;
      eEvt[t]       = 1'b1;
      eEvtData      = fifo.pop_front();
      eMon          = eEvtData;
      eSent         = 1'b1;
      eId           = NB_COREID'(t);
      nextActive[t] = 1'b1;
      mBurst        = 0;
    end else begin
      mBurst = 0;
    end
    mActive = nextActive;
  endtask

  task automatic checkRegistered();
    checkOutput("core_ack", core_ack, eAck);
    checkOutput("q_enq", q_enq, eEnq);
    if (eEnq) checkOutput("q_enq_data", q_enq_data, eEnqData);
    checkOutput("core_evt_vld", core_evt_vld, eEvt);
    if (eSent) checkOutput("core_evt_data", core_evt_data, eEvtData);
    checkOutput("sent_msg_vld", sent_msg_vld, eSent);
    checkOutput("rcv_msg_vld", rcv_msg_vld, eRcv);
    checkOutput("mon_msg", mon_msg, eMon);
    checkOutput("mon_core_id", mon_core_id, eId);
    checkOutput("core_active", core_active, mActive);
  endtask

  // Drive one decision cycle (called just after a falling edge), check q_deq
  // combinationally, then check registered outputs after the rising edge.
  task automatic applyStimulus(input logic [NUM_CORE-1:0] req,
                               input logic [NUM_CORE-1:0] done, input logic full);
    core_req  = req;
    core_done = done;
    q_full    = full;
    for (int i = 0; i < NUM_CORE; i++) core_msg[i*MSG_WID +: MSG_WID] = $urandom;
    q_empty = (fifo.size() == 0);
    q_data  = q_empty ? $urandom : fifo[0];
    #1;
    modelDecide();
    checkOutput("q_deq", q_deq, eQDeq);
    @(posedge clk);
    @(negedge clk);
    checkRegistered();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sentCnt;
    logic [9:0]  idSeq;
    logic [11:0] opSeq;
    reset = 1'b1; core_req = '0; core_done = '0; core_msg = '0; q_full = 1'b0;
    q_empty = 1'b1; q_data = '0; min_time = '0; min_time_vld = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_q_deq", q_deq, 0);
    checkRegistered();
    reset = 1'b0;

    // Scenario 1: three queued events go to cores 0,1,2 back to back.
    fifo.push_back(32'd5); fifo.push_back(32'd7); fifo.push_back(32'd9);
    sentCnt = 0;
    repeat (3) begin
      applyStimulus('0, '0, 1'b0);
      if (sent_msg_vld) sentCnt++;
    end
    checkOutput("s1_active", core_active, 4'b0111);
    checkOutput("s1_sent_pulses", sentCnt, 3);

    // Scenario 2: all cores returning, empty queue -> 0,1,2,3,0.
    idSeq = '0;
    repeat (5) begin
      applyStimulus(4'b1111, '0, 1'b0);
      if (rcv_msg_vld) idSeq = {idSeq[7:0], mon_core_id};
    end
    checkOutput("s2_ack_order", idSeq, 10'b00_01_10_11_00);

    // Scenario 3: one quiet cycle clears the burst, then RETx4, DSP, RET.
    applyStimulus('0, '0, 1'b0);
    fifo.push_back(32'h11); fifo.push_back(32'h13);
    opSeq = '0;
    repeat (6) begin
      applyStimulus(4'b0010, '0, 1'b0);
      opSeq = {opSeq[9:0], sent_msg_vld, rcv_msg_vld};
    end
    checkOutput("s3_op_order", opSeq, 12'b01_01_01_01_10_01);

    // Scenario 4: all busy, core 2 finishes at N, gets the head at N+2.
    applyStimulus('0, 4'b0100, 1'b0);
    checkOutput("s4_no_early_dsp", core_evt_vld, 4'b0000);
    applyStimulus('0, '0, 1'b0);
    checkOutput("s4_evt_vld", core_evt_vld, 4'b0100);

    // Scenario 5: q_full blocks return only; dropping it lets the ack through.
    fifo.push_back(32'h21);
    applyStimulus('0, 4'b0001, 1'b1);
    applyStimulus(4'b0001, '0, 1'b1);
    checkOutput("s5_full_ack", core_ack, 4'b0000);
    checkOutput("s5_full_enq", q_enq, 0);
    checkOutput("s5_full_dsp", core_evt_vld, 4'b0001);
    applyStimulus(4'b0001, '0, 1'b0);
    checkOutput("s5_ack", core_ack, 4'b0001);
    checkOutput("s5_enq", q_enq, 1);

`ifdef DISPATCH_WINDOW_EN
    // Window: head t=400 stalls at min_time=100, goes at min_time=200.
    applyStimulus('0, 4'b0010, 1'b0);
    min_time_vld = 1'b1; min_time = 16'd100;
    fifo.push_back(32'd400);
    applyStimulus('0, '0, 1'b0);
    checkOutput("win_blocked", sent_msg_vld, 0);
    min_time = 16'd200;
    applyStimulus('0, '0, 1'b0);
    checkOutput("win_open", core_evt_vld, 4'b0010);
    min_time_vld = 1'b0;
`endif

    // Reset in the middle of a return: everything drops at once.
    applyStimulus(4'b1111, '0, 1'b0);
    checkOutput("mid_rst_rcv_before", rcv_msg_vld, 1);
    fifo.push_back(32'h33);
    q_empty = 1'b0; q_data = fifo[0];
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_q_deq", q_deq, 0);
    checkOutput("mid_rst_ack", core_ack, 0);
    checkOutput("mid_rst_enq", q_enq, 0);
    checkOutput("mid_rst_enq_data", q_enq_data, 0);
    checkOutput("mid_rst_evt", core_evt_vld, 0);
    checkOutput("mid_rst_evt_data", core_evt_data, 0);
    checkOutput("mid_rst_mon", mon_msg, 0);
    checkOutput("mid_rst_sent", sent_msg_vld, 0);
    checkOutput("mid_rst_rcv", rcv_msg_vld, 0);
    checkOutput("mid_rst_id", mon_core_id, 0);
    checkOutput("mid_rst_active", core_active, 0);
    modelReset();
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (fifo.size() < 6 && $urandom_range(0, 1) == 1) fifo.push_back($urandom);
      min_time     = TIME_WID'($urandom);
      min_time_vld = ($urandom_range(0, 3) == 0);
      applyStimulus(4'($urandom) & 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                    ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
